// File: rtl/decode_regfile_sb_if.sv
// Decode-stage register file / scoreboard bundle: read selects and data, writeback,
// issue tracking and flush. Sideband signalling only; there is no valid/ready pair.
interface decode_regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int LAT_W  = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]     rsel;
    logic [NRD*DATA_W-1:0] rdat;
    logic [NRD-1:0]        busy;
    logic                  WEN;
    logic [AW-1:0]         wsel;
    logic [DATA_W-1:0]     wdat;
    logic                  issue;
    logic [AW-1:0]         isel;
    logic [LAT_W-1:0]      ilat;
    logic                  flush;
    logic                  pend_any;

    // Decode logic / bench side.
    modport master (
        output rsel, WEN, wsel, wdat, issue, isel, ilat, flush,
        input  rdat, busy, pend_any
    );

    // Register file side.
    modport slave (
        input  rsel, WEN, wsel, wdat, issue, isel, ilat, flush,
        output rdat, busy, pend_any
    );
endinterface

// File: rtl/decode_regfile_sb.sv
// Parametrised decode register file with write-through bypass on every read port
// and a per-register latency scoreboard that flags reads of not-yet-forwardable results.
module decode_regfile_sb #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int LAT_W  = 2
) (
    input  logic               CLK,
    input  logic               RST,
    decode_regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [DATA_W-1:0]     r_regs [NREGS];
    logic [LAT_W-1:0]      r_cnt  [NREGS];
    logic                  r_pend_any;
    logic [LAT_W-1:0]      w_cnt_nxt [NREGS];
    logic                  w_pend_nxt;
    logic [NRD*DATA_W-1:0] w_rdat;
    logic [NRD-1:0]        w_busy;

    // Scoreboard next state: flush beats issue, issue beats writeback clear and countdown.
    always_comb begin
        w_pend_nxt = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            w_cnt_nxt[r] = '0;
            if (r == 0 || bus.flush) begin
                w_cnt_nxt[r] = '0;
            end else if (bus.issue && bus.isel == AW'(r)) begin
                w_cnt_nxt[r] = bus.ilat;
            end else if (bus.WEN && bus.wsel == AW'(r)) begin
                w_cnt_nxt[r] = '0;
            end else if (r_cnt[r] != '0) begin
                w_cnt_nxt[r] = r_cnt[r] - LAT_W'(1);
            end
            w_pend_nxt = w_pend_nxt | (w_cnt_nxt[r] != '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
                r_cnt[r]  <= '0;
            end
            r_pend_any <= 1'b0;
        end else begin
            if (bus.WEN && bus.wsel != '0) begin
                r_regs[bus.wsel] <= bus.wdat;
            end
            for (int r = 0; r < NREGS; r++) begin
                r_cnt[r] <= w_cnt_nxt[r];
            end
            r_pend_any <= w_pend_nxt;
        end
    end

    // Busy reflects current counters only; same-cycle issue/writeback is not looked ahead at.
    always_comb begin
        w_rdat = '0;
        w_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (bus.rsel[i*AW +: AW] != '0) begin
                w_busy[i] = (r_cnt[bus.rsel[i*AW +: AW]] != '0);
                if (bus.WEN && bus.wsel == bus.rsel[i*AW +: AW]) begin
                    w_rdat[i*DATA_W +: DATA_W] = bus.wdat;
                end else begin
                    w_rdat[i*DATA_W +: DATA_W] = r_regs[bus.rsel[i*AW +: AW]];
                end
            end
        end
    end

    assign bus.rdat     = w_rdat;
    assign bus.busy     = w_busy;
    assign bus.pend_any = r_pend_any;
endmodule

// File: tb/tb_decode_regfile_sb.sv
// Bench for decode_regfile_sb: directed scenarios plus randomized traffic checked against
// an expiry-time model of the scoreboard and a plain array model of the register file.
module tb_decode_regfile_sb;
    localparam int AW_A = 5;
    localparam int AW_B = 4;

    logic CLK;
    logic RST;

    decode_regfile_sb_if #(.DATA_W(32), .NREGS(32), .NRD(2), .LAT_W(2)) bus_a ();
    decode_regfile_sb_if #(.DATA_W(16), .NREGS(16), .NRD(3), .LAT_W(2)) bus_b ();

    decode_regfile_sb #(.DATA_W(32), .NREGS(32), .NRD(2), .LAT_W(2)) dut_a (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_a)
    );

    decode_regfile_sb #(.DATA_W(16), .NREGS(16), .NRD(3), .LAT_W(2)) dut_b (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_b)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- scoreboard bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each register remembers the edge number after which its result is forwardable.
    logic [31:0] m_reg [32];
    int          m_exp [32];
    int          edge_cnt = 0;

    always @(posedge CLK) begin
        edge_cnt++;
        if (RST) begin
            for (int r = 0; r < 32; r++) begin
                m_reg[r] = '0;
                m_exp[r] = 0;
            end
        end else begin
            if (bus_a.WEN && bus_a.wsel != 0) m_reg[bus_a.wsel] = bus_a.wdat;
            if (bus_a.flush) begin
                for (int r = 0; r < 32; r++) m_exp[r] = 0;
            end else begin
                if (bus_a.WEN) m_exp[bus_a.wsel] = 0;
                if (bus_a.issue && bus_a.isel != 0) m_exp[bus_a.isel] = edge_cnt + int'(bus_a.ilat);
            end
        end
    end

    int          c_sel;
    logic [31:0] c_rdat;
    logic        c_busy;
    logic        c_pend;

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                c_sel = int'(bus_a.rsel[i*AW_A +: AW_A]);
                if (c_sel == 0) c_rdat = '0;
                else if (bus_a.WEN && int'(bus_a.wsel) == c_sel) c_rdat = bus_a.wdat;
                else c_rdat = m_reg[c_sel];
                c_busy = (c_sel != 0) && (edge_cnt < m_exp[c_sel]);
                chk($sformatf("model_rdat%0d", i), 64'(bus_a.rdat[i*32 +: 32]), 64'(c_rdat));
                chk($sformatf("model_busy%0d", i), 64'(bus_a.busy[i]), 64'(c_busy));
            end
            c_pend = 1'b0;
            for (int r = 1; r < 32; r++) if (edge_cnt < m_exp[r]) c_pend = 1'b1;
            chk("model_pend_any", 64'(bus_a.pend_any), 64'(c_pend));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_a();
        bus_a.WEN   = 1'b0;
        bus_a.issue = 1'b0;
        bus_a.flush = 1'b0;
    endtask

    task automatic set_rsel_a(input int p, input int sel);
        bus_a.rsel[p*AW_A +: AW_A] = AW_A'(sel);
    endtask

    task automatic issue_a(input int sel, input int lat);
        bus_a.issue = 1'b1;
        bus_a.isel  = AW_A'(sel);
        bus_a.ilat  = 2'(lat);
    endtask

    task automatic write_a(input int sel, input logic [31:0] dat);
        bus_a.WEN  = 1'b1;
        bus_a.wsel = AW_A'(sel);
        bus_a.wdat = dat;
    endtask

    task automatic random_cycle();
        for (int i = 0; i < 2; i++)
            set_rsel_a(i, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31));
        bus_a.WEN   = ($urandom_range(0, 99) < 40);
        bus_a.wsel  = AW_A'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31));
        bus_a.wdat  = $urandom;
        bus_a.issue = ($urandom_range(0, 99) < 50);
        bus_a.isel  = AW_A'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31));
        bus_a.ilat  = 2'($urandom_range(0, 3));
        bus_a.flush = ($urandom_range(0, 99) < 4);
        RST         = ($urandom_range(0, 199) == 0);
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST = 1'b1;
        bus_a.rsel = '0; bus_a.WEN = 0; bus_a.wsel = '0; bus_a.wdat = '0;
        bus_a.issue = 0; bus_a.isel = '0; bus_a.ilat = '0; bus_a.flush = 0;
        bus_b.rsel = '0; bus_b.WEN = 0; bus_b.wsel = '0; bus_b.wdat = '0;
        bus_b.issue = 0; bus_b.isel = '0; bus_b.ilat = '0; bus_b.flush = 0;

        step();
        chk_en = 1'b1;
        step();
        RST = 1'b0;

        // Reset state
        @(negedge CLK);
        chk("rst_rdat0", 64'(bus_a.rdat[31:0]), 64'h0);
        chk("rst_busy", 64'(bus_a.busy), 64'h0);
        chk("rst_pend", 64'(bus_a.pend_any), 64'h0);

        // Bypass then array read
        step();
        write_a(5, 32'hDEADBEEF);
        set_rsel_a(0, 5);
        @(negedge CLK);
        chk("bypass_rdat0", 64'(bus_a.rdat[31:0]), 64'hDEADBEEF);
        step();
        idle_a();
        @(negedge CLK);
        chk("array_rdat0", 64'(bus_a.rdat[31:0]), 64'hDEADBEEF);

        // Register 0
        step();
        write_a(0, 32'h1234);
        set_rsel_a(0, 0);
        @(negedge CLK);
        chk("r0_bypass", 64'(bus_a.rdat[31:0]), 64'h0);
        step();
        idle_a();
        issue_a(0, 3);
        set_rsel_a(1, 0);
        @(negedge CLK);
        chk("r0_read", 64'(bus_a.rdat[31:0]), 64'h0);
        step();
        idle_a();
        @(negedge CLK);
        chk("r0_busy", 64'(bus_a.busy[1]), 64'h0);
        chk("r0_pend", 64'(bus_a.pend_any), 64'h0);

        // Latency countdown: issue reg7 lat2
        issue_a(7, 2);
        set_rsel_a(1, 7);
        step();
        idle_a();
        @(negedge CLK);
        chk("cd_busy_t1", 64'(bus_a.busy[1]), 64'h1);
        chk("cd_pend_t1", 64'(bus_a.pend_any), 64'h1);
        step();
        @(negedge CLK);
        chk("cd_busy_t2", 64'(bus_a.busy[1]), 64'h1);
        step();
        @(negedge CLK);
        chk("cd_busy_t3", 64'(bus_a.busy[1]), 64'h0);
        chk("cd_pend_t3", 64'(bus_a.pend_any), 64'h0);

        // Early writeback, then same-edge issue+writeback
        issue_a(9, 3);
        set_rsel_a(0, 9);
        step();
        idle_a();
        write_a(9, 32'h99);
        @(negedge CLK);
        chk("ewb_busy_before", 64'(bus_a.busy[0]), 64'h1);
        step();
        idle_a();
        @(negedge CLK);
        chk("ewb_busy_after", 64'(bus_a.busy[0]), 64'h0);
        issue_a(9, 3);
        write_a(9, 32'h77);
        step();
        idle_a();
        @(negedge CLK);
        chk("prio_busy", 64'(bus_a.busy[0]), 64'h1);
        repeat (3) step();

        // Flush beats same-edge issue
        set_rsel_a(0, 3);
        set_rsel_a(1, 4);
        issue_a(4, 2);
        step();
        issue_a(3, 2);
        step();
        idle_a();
        @(negedge CLK);
        chk("fl_pre_busy", 64'(bus_a.busy), 64'h3);
        bus_a.flush = 1'b1;
        issue_a(6, 3);
        step();
        idle_a();
        set_rsel_a(1, 6);
        @(negedge CLK);
        chk("fl_busy", 64'(bus_a.busy), 64'h0);
        chk("fl_pend", 64'(bus_a.pend_any), 64'h0);

        // Reset mid-countdown overrides issue/write/flush
        issue_a(7, 3);
        step();
        idle_a();
        RST = 1'b1;
        issue_a(8, 3);
        write_a(5, 32'h1);
        bus_a.flush = 1'b1;
        step();
        RST = 1'b0;
        idle_a();
        set_rsel_a(0, 5);
        set_rsel_a(1, 7);
        @(negedge CLK);
        chk("rst2_rdat0", 64'(bus_a.rdat[31:0]), 64'h0);
        chk("rst2_busy", 64'(bus_a.busy), 64'h0);
        chk("rst2_pend", 64'(bus_a.pend_any), 64'h0);

        // Multi-port instance: 3 ports all reading reg2
        step();
        bus_b.WEN  = 1'b1;
        bus_b.wsel = 4'd2;
        bus_b.wdat = 16'hBEEF;
        bus_b.rsel = {3{4'd2}};
        @(negedge CLK);
        for (int i = 0; i < 3; i++)
            chk($sformatf("mp_bypass%0d", i), 64'(bus_b.rdat[i*16 +: 16]), 64'hBEEF);
        step();
        bus_b.WEN   = 1'b0;
        bus_b.issue = 1'b1;
        bus_b.isel  = 4'd2;
        bus_b.ilat  = 2'd1;
        step();
        bus_b.issue = 1'b0;
        @(negedge CLK);
        chk("mp_busy", 64'(bus_b.busy), 64'h7);
        chk("mp_pend", 64'(bus_b.pend_any), 64'h1);
        for (int i = 0; i < 3; i++)
            chk($sformatf("mp_rdat%0d", i), 64'(bus_b.rdat[i*16 +: 16]), 64'hBEEF);
        step();
        @(negedge CLK);
        chk("mp_busy_done", 64'(bus_b.busy), 64'h0);
        chk("mp_pend_done", 64'(bus_b.pend_any), 64'h0);

        // Randomized traffic against the model
        step();
        for (int n = 0; n < 3000; n++) random_cycle();
        RST = 1'b0;
        idle_a();
        repeat (4) step();

        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
